// File: rtl/uart_rx_frame_check.sv
// UART receive frame checker: deserialises mid-bit samples LSB first, checks
// optional parity and one/two stop bits, and counts errored frames.
module uart_rx_frame_check #(
  parameter int DATA_WIDTH = 8,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  chk_start,
  input  logic                  bit_valid,
  input  logic                  sampled_bit,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  stop_num,
  input  logic                  err_clr,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  frame_done,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic [ERR_CNT_W-1:0]  err_cnt
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        bit_cnt_reg, bit_cnt_next;
  logic [DATA_WIDTH-1:0]   shift_reg, shift_next;
  logic                    stop_cnt_reg, stop_cnt_next;
  logic                    par_en_l_reg, par_en_l_next;
  logic                    par_typ_l_reg, par_typ_l_next;
  logic                    stop_num_l_reg, stop_num_l_next;
  logic                    par_acc_reg, par_acc_next;
  logic                    stp_acc_reg, stp_acc_next;

  logic                    busy_reg;
  logic [DATA_WIDTH-1:0]   p_data_reg;
  logic                    frame_done_reg;
  logic                    data_valid_reg;
  logic                    par_err_reg;
  logic                    stp_err_reg;
  logic [ERR_CNT_W-1:0]    err_cnt_reg, err_cnt_next;
  logic                    errored_done;

  // Frame sequencing and accumulation
  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    stop_cnt_next   = stop_cnt_reg;
    par_en_l_next   = par_en_l_reg;
    par_typ_l_next  = par_typ_l_reg;
    stop_num_l_next = stop_num_l_reg;
    par_acc_next    = par_acc_reg;
    stp_acc_next    = stp_acc_reg;

    case (state_reg)
      IDLE: begin
        if (chk_start) begin
          par_en_l_next   = par_en;
          par_typ_l_next  = par_typ;
          stop_num_l_next = stop_num;
          bit_cnt_next    = '0;
          shift_next      = '0;
          stop_cnt_next   = 1'b0;
          par_acc_next    = 1'b0;
          stp_acc_next    = 1'b0;
          state_next      = DATA;
        end
      end
      DATA: begin
        if (bit_valid) begin
          shift_next   = {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
          bit_cnt_next = bit_cnt_reg + CNT_W'(1);
          if (bit_cnt_reg == CNT_W'(DATA_WIDTH - 1))
            state_next = par_en_l_reg ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_valid) begin
          par_acc_next = (^shift_reg) ^ sampled_bit ^ par_typ_l_reg;
          state_next   = STOP;
        end
      end
      STOP: begin
        if (bit_valid) begin
          if (!sampled_bit)
            stp_acc_next = 1'b1;
          stop_cnt_next = 1'b1;
          // Second stop bit is still sampled when the first was bad
          if (stop_cnt_reg == stop_num_l_reg)
            state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      stop_cnt_reg   <= 1'b0;
      par_en_l_reg   <= 1'b0;
      par_typ_l_reg  <= 1'b0;
      stop_num_l_reg <= 1'b0;
      par_acc_reg    <= 1'b0;
      stp_acc_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      stop_cnt_reg   <= stop_cnt_next;
      par_en_l_reg   <= par_en_l_next;
      par_typ_l_reg  <= par_typ_l_next;
      stop_num_l_reg <= stop_num_l_next;
      par_acc_reg    <= par_acc_next;
      stp_acc_reg    <= stp_acc_next;
    end
  end

  // Result outputs are loaded on the edge that enters DONE so they are
  // visible during the DONE cycle itself.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      busy_reg       <= 1'b0;
      p_data_reg     <= '0;
      frame_done_reg <= 1'b0;
      data_valid_reg <= 1'b0;
      par_err_reg    <= 1'b0;
      stp_err_reg    <= 1'b0;
    end else begin
      busy_reg <= (state_next != IDLE);
      if (state_next == DONE) begin
        p_data_reg     <= shift_reg;
        frame_done_reg <= 1'b1;
        par_err_reg    <= par_acc_next;
        stp_err_reg    <= stp_acc_next;
        data_valid_reg <= ~(par_acc_next | stp_acc_next);
      end else begin
        frame_done_reg <= 1'b0;
        par_err_reg    <= 1'b0;
        stp_err_reg    <= 1'b0;
        data_valid_reg <= 1'b0;
      end
    end
  end

  // Errored-frame counter; a clear coinciding with an errored frame keeps that frame
  assign errored_done = (state_reg == DONE) && (par_err_reg || stp_err_reg);

  always_comb begin
    err_cnt_next = err_cnt_reg;
    if (err_clr)
      err_cnt_next = errored_done ? ERR_CNT_W'(1) : '0;
    else if (errored_done && (err_cnt_reg != {ERR_CNT_W{1'b1}}))
      err_cnt_next = err_cnt_reg + ERR_CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      err_cnt_reg <= '0;
    else
      err_cnt_reg <= err_cnt_next;
  end

  assign busy       = busy_reg;
  assign p_data     = p_data_reg;
  assign frame_done = frame_done_reg;
  assign data_valid = data_valid_reg;
  assign par_err    = par_err_reg;
  assign stp_err    = stp_err_reg;
  assign err_cnt    = err_cnt_reg;

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Directed bench for uart_rx_frame_check (8 data bits, 2-bit error counter).
module tb_uart_rx_frame_check;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       chk_start = 1'b0;
  logic       bit_valid = 1'b0;
  logic       sampled_bit = 1'b0;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic       stop_num = 1'b0;
  logic       err_clr = 1'b0;
  logic       busy;
  logic [7:0] p_data;
  logic       frame_done;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic [1:0] err_cnt;

  int checks = 0;
  int errors = 0;

  uart_rx_frame_check #(.DATA_WIDTH(8), .ERR_CNT_W(2)) dut (
    .CLK(CLK), .RST(RST), .chk_start(chk_start), .bit_valid(bit_valid),
    .sampled_bit(sampled_bit), .par_en(par_en), .par_typ(par_typ),
    .stop_num(stop_num), .err_clr(err_clr), .busy(busy), .p_data(p_data),
    .frame_done(frame_done), .data_valid(data_valid), .par_err(par_err),
    .stp_err(stp_err), .err_cnt(err_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic pulse_start();
    chk_start = 1'b1;
    @(posedge CLK); #1;
    chk_start = 1'b0;
  endtask

  // One idle cycle, then a one-cycle strobe
  task automatic strobe(input logic b);
    @(posedge CLK); #1;
    bit_valid = 1'b1;
    sampled_bit = b;
    @(posedge CLK); #1;
    bit_valid = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] d);
    for (int i = 0; i < 8; i++) strobe(d[i]);
  endtask

  task automatic test_reset();
    RST = 1'b0;
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid got %b want 0", data_valid); end
    checks++; if ({par_err, stp_err} !== 2'b00) begin errors++; $display("FAIL reset_errs got %b want 00", {par_err, stp_err}); end
    checks++; if (p_data !== 8'h00) begin errors++; $display("FAIL reset_p_data got %h want 00", p_data); end
    checks++; if (err_cnt !== 2'd0) begin errors++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    $display("reset: busy=%b p_data=%h err_cnt=%0d", busy, p_data, err_cnt);
  endtask

  task automatic test_clean();
    par_en = 1'b0; stop_num = 1'b0;
    pulse_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clean_busy_rise got %b want 1", busy); end
    send_data(8'hA5);
    strobe(1'b1);
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL clean_frame_done got %b want 1", frame_done); end
    checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL clean_data_valid got %b want 1", data_valid); end
    checks++; if (p_data !== 8'hA5) begin errors++; $display("FAIL clean_p_data got %h want a5", p_data); end
    checks++; if ({par_err, stp_err} !== 2'b00) begin errors++; $display("FAIL clean_errs got %b want 00", {par_err, stp_err}); end
    $display("clean: p_data=%h frame_done=%b data_valid=%b", p_data, frame_done, data_valid);
    @(posedge CLK); #1;
    checks++; if ({busy, frame_done, data_valid} !== 3'b000) begin errors++; $display("FAIL clean_after got %b want 000", {busy, frame_done, data_valid}); end
    checks++; if (err_cnt !== 2'd0) begin errors++; $display("FAIL clean_err_cnt got %0d want 0", err_cnt); end
  endtask

  task automatic test_parity();
    par_en = 1'b1; par_typ = 1'b0; stop_num = 1'b0;
    // 0xA5 has four ones: parity bit 1 is wrong for even parity
    pulse_start(); send_data(8'hA5); strobe(1'b1); strobe(1'b1);
    checks++; if ({frame_done, par_err, stp_err, data_valid} !== 4'b1100) begin errors++; $display("FAIL parity_bad flags got %b want 1100", {frame_done, par_err, stp_err, data_valid}); end
    $display("parity bad: par_err=%b data_valid=%b", par_err, data_valid);
    @(posedge CLK); #1;
    checks++; if (err_cnt !== 2'd1) begin errors++; $display("FAIL parity_bad_cnt got %0d want 1", err_cnt); end
    pulse_start(); send_data(8'hA5); strobe(1'b0); strobe(1'b1);
    checks++; if ({frame_done, par_err, stp_err, data_valid} !== 4'b1001) begin errors++; $display("FAIL parity_good flags got %b want 1001", {frame_done, par_err, stp_err, data_valid}); end
    $display("parity good: par_err=%b data_valid=%b", par_err, data_valid);
    @(posedge CLK); #1;
    checks++; if (err_cnt !== 2'd1) begin errors++; $display("FAIL parity_good_cnt got %0d want 1", err_cnt); end
  endtask

  task automatic test_stop();
    par_en = 1'b1; par_typ = 1'b1; stop_num = 1'b1;
    pulse_start(); send_data(8'h01); strobe(1'b0); strobe(1'b0);
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL stop_first_done got %b want 0", frame_done); end
    strobe(1'b1);
    checks++; if ({frame_done, par_err, stp_err, data_valid} !== 4'b1010) begin errors++; $display("FAIL stop_flags got %b want 1010", {frame_done, par_err, stp_err, data_valid}); end
    checks++; if (p_data !== 8'h01) begin errors++; $display("FAIL stop_p_data got %h want 01", p_data); end
    $display("two stops: stp_err=%b par_err=%b p_data=%h", stp_err, par_err, p_data);
    @(posedge CLK); #1;
    checks++; if (err_cnt !== 2'd2) begin errors++; $display("FAIL stop_cnt got %0d want 2", err_cnt); end
    par_en = 1'b0; par_typ = 1'b0; stop_num = 1'b0;
  endtask

  task automatic test_saturate();
    err_clr = 1'b1;
    @(posedge CLK); #1;
    err_clr = 1'b0;
    checks++; if (err_cnt !== 2'd0) begin errors++; $display("FAIL clr_idle got %0d want 0", err_cnt); end
    for (int n = 1; n <= 5; n++) begin
      pulse_start(); send_data(8'h81); strobe(1'b0);
      @(posedge CLK); #1;
      checks++;
      if (err_cnt !== ((n > 3) ? 2'd3 : 2'(n))) begin
        errors++; $display("FAIL sat_frame%0d got %0d want %0d", n, err_cnt, (n > 3) ? 3 : n);
      end
      $display("errored frame %0d: err_cnt=%0d", n, err_cnt);
    end
    pulse_start(); send_data(8'h81); strobe(1'b0);
    err_clr = 1'b1;
    @(posedge CLK); #1;
    err_clr = 1'b0;
    checks++; if (err_cnt !== 2'd1) begin errors++; $display("FAIL clr_with_error got %0d want 1", err_cnt); end
    $display("clear with errored frame: err_cnt=%0d", err_cnt);
  endtask

  task automatic test_reset_mid();
    int extra;
    pulse_start();
    for (int i = 0; i < 4; i++) strobe(i[0] ? 1'b0 : 1'b1);
    RST = 1'b0;
    #1;
    checks++; if ({busy, frame_done, data_valid, par_err, stp_err} !== 5'b0) begin errors++; $display("FAIL midreset_flags got %b want 00000", {busy, frame_done, data_valid, par_err, stp_err}); end
    checks++; if (p_data !== 8'h00) begin errors++; $display("FAIL midreset_p_data got %h want 00", p_data); end
    checks++; if (err_cnt !== 2'd0) begin errors++; $display("FAIL midreset_err_cnt got %0d want 0", err_cnt); end
    extra = 0;
    repeat (3) begin
      @(posedge CLK); #1;
      if (frame_done) extra++;
    end
    RST = 1'b1;
    repeat (3) begin
      @(posedge CLK); #1;
      if (frame_done) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL midreset_no_done got %0d pulses want 0", extra); end
    pulse_start(); send_data(8'h3C); strobe(1'b1);
    checks++; if ({frame_done, data_valid} !== 2'b11) begin errors++; $display("FAIL midreset_frame flags got %b want 11", {frame_done, data_valid}); end
    checks++; if (p_data !== 8'h3C) begin errors++; $display("FAIL midreset_p_data2 got %h want 3c", p_data); end
    $display("after mid-frame reset: p_data=%h", p_data);
    @(posedge CLK); #1;
  endtask

  task automatic test_latch();
    int extra;
    logic [7:0] d;
    d = 8'h5A;
    par_en = 1'b0; stop_num = 1'b0;
    pulse_start();
    for (int i = 0; i < 3; i++) strobe(d[i]);
    par_en = 1'b1; stop_num = 1'b1;
    pulse_start();
    for (int i = 3; i < 8; i++) strobe(d[i]);
    strobe(1'b1);
    checks++; if ({frame_done, data_valid} !== 2'b11) begin errors++; $display("FAIL latch_flags got %b want 11", {frame_done, data_valid}); end
    checks++; if (p_data !== 8'h5A) begin errors++; $display("FAIL latch_p_data got %h want 5a", p_data); end
    $display("latched settings: p_data=%h frame_done=%b", p_data, frame_done);
    extra = 0;
    repeat (6) begin
      @(posedge CLK); #1;
      if (frame_done || busy) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL latch_single_frame got %0d busy/done cycles want 0", extra); end
    par_en = 1'b0; stop_num = 1'b0;
  endtask

  task automatic test_back_to_back();
    // chk_start during DONE is dropped
    pulse_start(); send_data(8'hC3); strobe(1'b1);
    chk_start = 1'b1;
    @(posedge CLK); #1;
    chk_start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_in_done got busy %b want 0", busy); end
    // Next frame started in the first IDLE cycle after DONE, with a stray strobe alongside
    pulse_start(); send_data(8'h0F); strobe(1'b1);
    checks++; if (p_data !== 8'h0F) begin errors++; $display("FAIL b2b_first got %h want 0f", p_data); end
    @(posedge CLK); #1;
    chk_start = 1'b1; bit_valid = 1'b1; sampled_bit = 1'b1;
    @(posedge CLK); #1;
    chk_start = 1'b0; bit_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy %b want 1", busy); end
    send_data(8'h96); strobe(1'b1);
    checks++; if ({frame_done, data_valid} !== 2'b11) begin errors++; $display("FAIL b2b_flags got %b want 11", {frame_done, data_valid}); end
    checks++; if (p_data !== 8'h96) begin errors++; $display("FAIL b2b_p_data got %h want 96", p_data); end
    $display("back to back: p_data=%h", p_data);
    @(posedge CLK); #1;
  endtask

  initial begin
    test_reset();
    test_clean();
    test_parity();
    test_stop();
    test_saturate();
    test_reset_mid();
    test_latch();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_rx_frame_check.md
# uart_rx_frame_check

Parametrised UART receive frame checker. It consumes mid-bit samples from the RX data sampler and tracks frame position with its own state machine. It deserialises the data bits LSB first and checks optional even/odd parity and one or two stop bits. At the end of each frame it reports the byte and its error flags, and keeps a saturating count of errored frames. It sits between the RX edge/bit counter and the RX output register, replacing the combinational stop-bit checker and the separate parity checker.

## Interface
- DATA_WIDTH, 8, data bits per frame, legal 5..9
- ERR_CNT_W, 8, width of errored-frame counter
- CLK  input  1  system clock, rising edge
- RST  input  1  asynchronous, active-low reset
- chk_start  input  1  one-cycle pulse: start bit validated, frame begins
- bit_valid  input  1  one-cycle strobe: sampled_bit holds the current bit's mid-bit value
- sampled_bit  input  1  sampled RX line value
- par_en  input  1  parity bit present and checked
- par_typ  input  1  0 = even, 1 = odd
- stop_num  input  1  0 = one stop bit, 1 = two stop bits
- err_clr  input  1  synchronous clear of err_cnt
- busy  output  1  frame in progress
- p_data  output  DATA_WIDTH  received data, held until next frame_done
- frame_done  output  1  one-cycle pulse at end of frame
- data_valid  output  1  one-cycle pulse with frame_done when no error
- par_err  output  1  one-cycle pulse with frame_done on parity error
- stp_err  output  1  one-cycle pulse with frame_done on stop error
- err_cnt  output  ERR_CNT_W  saturating count of errored frames

## Operation
- States: IDLE, DATA, PARITY, STOP, DONE.
- IDLE
  - On chk_start: latch par_en, par_typ and stop_num into frame-local registers.
  - Clear the bit counter, shift register and error accumulators, then go to DATA.
  - bit_valid is ignored in IDLE.
- DATA
  - Each bit_valid shifts sampled_bit into the shift register MSB and shifts right, so the first bit lands in bit 0 after the last shift. It also increments the bit counter.
  - After the DATA_WIDTH-th bit, go to PARITY if latched par_en is set, else to STOP.
- PARITY
  - On bit_valid, par_err_acc = (^shift_reg) ^ sampled_bit ^ latched par_typ, then go to STOP.
  - Even parity: total ones across data and parity bit must be even. Odd parity: total must be odd.
- STOP
  - On each bit_valid, set stp_err_acc if sampled_bit == 0.
  - After 1 or 2 stop strobes (per latched stop_num), go to DONE.
  - With two stop bits, the second bit is sampled even if the first was 0.
- DONE (one cycle)
  - Load p_data from the shift register and assert frame_done.
  - Assert par_err and stp_err from the accumulators.
  - Assert data_valid if neither accumulator is set.
  - Go to IDLE.
- busy = 1 in DATA, PARITY, STOP and DONE.
- chk_start while busy is ignored.
- par_en, par_typ and stop_num changes mid-frame have no effect until the next chk_start.
- err_cnt
  - Increments in DONE when par_err or stp_err is asserted. Saturates at all-ones.
  - err_clr has priority: if err_clr coincides with an errored DONE, err_cnt becomes 1. Otherwise err_clr sets it to 0.
- Reset (asynchronous, any state)
  - Return to IDLE.
  - busy, frame_done, data_valid, par_err, stp_err = 0; p_data = 0; err_cnt = 0.
  - Accumulators and counters are cleared.
  - A partially received frame is discarded with no pulse.

## Timing
- Registered outputs; all pulses are exactly one CLK cycle wide.
- frame_done, data_valid, par_err and stp_err assert in the cycle after the CLK edge that samples the final stop bit_valid. This is the DONE state: latency of 1 cycle from the last strobe.
- p_data updates on the edge entering DONE's output cycle and holds until the next frame's DONE.
- busy rises in the cycle after chk_start and falls in the cycle after DONE.
- A chk_start coincident with DONE is ignored.
- A chk_start in the first IDLE cycle after DONE is accepted, giving a back-to-back frame gap of 1 cycle.
- bit_valid in the same cycle as chk_start is ignored; the first data bit must strobe at least 1 cycle later.
- Strobe spacing is arbitrary, at 1 cycle minimum.

## Test plan
- DATA_WIDTH=8, par_en=0, stop_num=0, send 0xA5 LSB first plus stop=1 -> frame_done and data_valid pulse, p_data=0xA5, par_err=stp_err=0, err_cnt=0.
- par_en=1, par_typ=0, data 0xA5, parity bit 1, stop=1 -> par_err=1, data_valid=0, err_cnt=1. Repeat with parity bit 0 -> clean frame, err_cnt stays 1.
- par_en=1, par_typ=1, stop_num=1, data 0x01, parity 0, stops 0 then 1 -> stp_err=1, par_err=0, frame_done 1 cycle after the second stop strobe.
- ERR_CNT_W=2, send 5 errored frames -> err_cnt sticks at 3. Assert err_clr coincident with a 6th errored DONE -> err_cnt=1.
- Assert RST low during the DATA state after 4 bits -> all outputs 0 immediately, no frame_done. After release, a full 0x3C frame -> p_data=0x3C.
- Toggle par_en, and pulse chk_start, mid-frame -> current frame still checked with the latched settings, no restart, single frame_done.
